// File: rtl/mult_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mult_arbiter_if
// Brief    : Requester-side operand/result handshake bundle for mult_arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface mult_arbiter_if #(
  parameter int N    = 32,
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [2*N-1:0]    rsp_c;
  logic              rsp_err;

  // Arbiter side
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_c, rsp_err
  );

  // Client side
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_c, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mult_arbiter
// Brief    : Round-robin arbiter sharing one multiplier among NREQ requesters.
// Revision : 1.0  initial release
// ============================================================================
module mult_arbiter #(
  parameter int N       = 32,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  mult_arbiter_if.slave           req_if,
  output logic                    mul_load,
  output logic                    mul_recieved,
  output logic [N-1:0]            mul_a,
  output logic [N-1:0]            mul_b,
  input  logic                    mul_done,
  input  logic                    mul_init,
  input  logic [2*N-1:0]          mul_c,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_RESP    = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  logic [2:0]     state_q, state_d;
  logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]  grant_id_q, grant_id_d;
  logic [N-1:0]   mul_a_q, mul_a_d;
  logic [N-1:0]   mul_b_q, mul_b_d;
  logic [2*N-1:0] rsp_c_q, rsp_c_d;
  logic           rsp_err_q, rsp_err_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           hi_found, lo_found;
  logic [IW-1:0]  hi_idx, lo_idx, win_idx;
  logic           grant;
  logic [NREQ-1:0] req_ready_w, rsp_valid_w;

  // Round-robin pick: first valid at or above rr_ptr, else first valid overall.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_if.req_valid[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = IW'(i);
      end
      if (req_if.req_valid[i] && !hi_found && (IW'(i) >= rr_ptr_q)) begin
        hi_found = 1'b1;
        hi_idx   = IW'(i);
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
  end

  assign grant = !rst && (state_q == S_IDLE) && mul_init && lo_found;

  always_comb begin
    req_ready_w = '0;
    rsp_valid_w = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready_w[i] = grant && (win_idx == IW'(i));
      rsp_valid_w[i] = (state_q == S_RESP) && (grant_id_q == IW'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    rsp_c_d    = rsp_c_q;
    rsp_err_d  = rsp_err_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          mul_a_d    = req_if.req_a[int'(win_idx)*N +: N];
          mul_b_d    = req_if.req_b[int'(win_idx)*N +: N];
          grant_id_d = win_idx;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done in the expiry cycle still yields a good result.
        if (mul_done) begin
          rsp_c_d   = mul_c;
          rsp_err_d = 1'b0;
          state_d   = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_c_d   = '0;
          rsp_err_d = 1'b1;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (req_if.rsp_ready[grant_id_q]) begin
          rr_ptr_d = (grant_id_q == IW'(NREQ - 1)) ? '0 : grant_id_q + 1'b1;
          state_d  = S_RELEASE;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      rsp_c_q    <= '0;
      rsp_err_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      rsp_c_q    <= rsp_c_d;
      rsp_err_q  <= rsp_err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign req_if.req_ready = req_ready_w;
  assign req_if.rsp_valid = rsp_valid_w;
  assign req_if.rsp_c     = rsp_c_q;
  assign req_if.rsp_err   = rsp_err_q;
  assign mul_load         = (state_q == S_LOAD);
  assign mul_recieved     = (state_q == S_RELEASE);
  assign mul_a            = mul_a_q;
  assign mul_b            = mul_b_q;
  assign busy             = (state_q != S_IDLE);
  assign grant_id         = grant_id_q;
endmodule
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_arbiter
// Brief    : Scoreboard bench for mult_arbiter with a behavioural multiplier.
// Revision : 1.0  initial release
// ============================================================================
module tb_mult_arbiter;
  logic        clk;
  logic        rst;
  logic        mul_load, mul_recieved, mul_done, mul_init, busy;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_c;
  logic [1:0]  grant_id;

  mult_arbiter_if #(.N(32), .NREQ(4)) bus ();

  mult_arbiter #(.N(32), .NREQ(4), .TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .req_if(bus),
    .mul_load(mul_load), .mul_recieved(mul_recieved),
    .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done),
    .mul_init(mul_init), .mul_c(mul_c), .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int id; logic [31:0] a; logic [31:0] b; } req_t;
  typedef struct { int id; logic [63:0] c; logic err; } exp_t;
  req_t pend[$];
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int loads = 0;
  int recvs = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (mul_load) loads <= loads + 1;
    if (mul_recieved) recvs <= recvs + 1;
  end

  // Behavioural multiplier: 8-cycle latency, holds done until recieved.
  logic        m_stall;
  logic [1:0]  m_st;
  logic [3:0]  m_cnt;
  logic [31:0] m_a, m_b;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_init <= 1'b1; mul_done <= 1'b0; mul_c <= '0;
      m_st <= 2'd0; m_cnt <= '0; m_a <= '0; m_b <= '0;
    end else begin
      case (m_st)
        2'd0: if (mul_load) begin
          m_a <= mul_a; m_b <= mul_b; mul_init <= 1'b0; m_cnt <= '0; m_st <= 2'd1;
        end
        2'd1: if (mul_recieved) m_st <= 2'd3;
              else if (!m_stall) begin
                if (m_cnt == 4'd7) begin
                  mul_done <= 1'b1; mul_c <= {32'd0, m_a} * {32'd0, m_b}; m_st <= 2'd2;
                end else m_cnt <= m_cnt + 4'd1;
              end
        2'd2: if (mul_recieved) begin mul_done <= 1'b0; m_st <= 2'd3; end
        default: begin mul_init <= 1'b1; m_st <= 2'd0; end
      endcase
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic drive();
    logic [3:0]   v;
    logic [127:0] a, b;
    int id;
    v = '0; a = '0; b = '0;
    for (int k = 0; k < pend.size(); k++) begin
      id = pend[k].id;
      if (!v[id]) begin
        v[id] = 1'b1;
        a[id*32 +: 32] = pend[k].a;
        b[id*32 +: 32] = pend[k].b;
      end
    end
    bus.req_valid = v; bus.req_a = a; bus.req_b = b;
  endtask

  // Clients: each requester presents its oldest pending pair until accepted.
  initial begin
    logic [3:0] acc;
    bit done_i;
    forever begin
      @(negedge clk);
      acc = bus.req_ready & bus.req_valid;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        done_i = 0;
        if (acc[i]) begin
          for (int k = 0; k < pend.size(); k++) begin
            if (!done_i && pend[k].id == i) begin pend.delete(k); done_i = 1; end
          end
        end
      end
      drive();
    end
  end

  // Monitor: every completed response handshake is matched against the scoreboard.
  always @(negedge clk) begin : mon
    int id;
    exp_t e;
    if (!rst && (bus.rsp_valid & bus.rsp_ready) != 4'd0) begin
      id = -1;
      for (int i = 0; i < 4; i++) if (bus.rsp_valid[i]) id = i;
      chk("rsp_onehot", 64'($countones(bus.rsp_valid)), 64'd1);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: got rsp_valid=%b expected none", bus.rsp_valid);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_id", 64'(id), 64'(e.id));
        chk("rsp_c", bus.rsp_c, e.c);
        chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
      end
    end
  end

  task automatic push_req(input int id, input logic [31:0] a, input logic [31:0] b);
    req_t r;
    r.id = id; r.a = a; r.b = b;
    pend.push_back(r);
  endtask

  task automatic push_exp(input int id, input logic [63:0] c, input logic err);
    exp_t e;
    e.id = id; e.c = c; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin @(negedge clk); n++; end
    chk("drain_outstanding", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_load(input string name);
    int n;
    n = 0;
    while (!mul_load && n < 300) begin @(negedge clk); n++; end
    chk(name, 64'(mul_load), 64'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, "_rsp_c"}, bus.rsp_c, 64'd0);
    chk({tag, "_rsp_err"}, 64'(bus.rsp_err), 64'd0);
    chk({tag, "_mul_load"}, 64'(mul_load), 64'd0);
    chk({tag, "_mul_recieved"}, 64'(mul_recieved), 64'd0);
    chk({tag, "_mul_a"}, 64'(mul_a), 64'd0);
    chk({tag, "_mul_b"}, 64'(mul_b), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_grant_id"}, 64'(grant_id), 64'd0);
  endtask

  initial begin
    int l0, r0, t_load, n;
    rst = 1'b1; m_stall = 1'b0;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 4'hF;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // All four at once, requester 0 re-requests after its first grant.
    push_req(0, 32'd1, 32'd10); push_req(0, 32'd9, 32'd9);
    push_req(1, 32'd2, 32'd10); push_req(2, 32'd3, 32'd10); push_req(3, 32'd4, 32'd10);
    push_exp(0, 64'd10, 1'b0); push_exp(1, 64'd20, 1'b0); push_exp(2, 64'd30, 1'b0);
    push_exp(3, 64'd40, 1'b0); push_exp(0, 64'd81, 1'b0);
    drain(400);

    // Single request.
    l0 = loads; r0 = recvs;
    push_req(0, 32'd5, 32'd3); push_exp(0, 64'd15, 1'b0);
    drain(100);
    chk("single_loads", 64'(loads - l0), 64'd1);
    chk("single_recvs", 64'(recvs - r0), 64'd1);

    // Backpressure on requester 1 with requester 3 waiting.
    bus.rsp_ready = 4'b1101;
    push_req(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF); push_req(3, 32'd2, 32'd3);
    push_exp(1, 64'hFFFF_FFFE_0000_0001, 1'b0); push_exp(3, 64'd6, 1'b0);
    n = 0;
    while (bus.rsp_valid != 4'b0010 && n < 100) begin @(negedge clk); n++; end
    for (int k = 0; k < 10; k++) begin
      chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'b0010);
      chk("bp_rsp_c", bus.rsp_c, 64'hFFFF_FFFE_0000_0001);
      chk("bp_rsp_err", 64'(bus.rsp_err), 64'd0);
      chk("bp_no_recieved", 64'(mul_recieved), 64'd0);
      chk("bp_no_ready", 64'(bus.req_ready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 4'hF;
    drain(100);

    // Timeout with a stalled multiplier.
    m_stall = 1'b1; r0 = recvs;
    push_req(2, 32'd7, 32'd7); push_exp(2, 64'd0, 1'b1);
    wait_load("to_load_seen");
    t_load = cyc;
    n = 0;
    while (bus.rsp_valid == 4'd0 && n < 300) begin @(negedge clk); n++; end
    chk("to_latency", 64'(cyc - t_load - 1), 64'd100);
    drain(50);
    chk("to_recvs", 64'(recvs - r0), 64'd1);
    m_stall = 1'b0;

    // Fairness between requesters 0 and 2.
    for (int k = 0; k < 3; k++) begin
      push_req(0, 32'd7, 32'd6); push_req(2, 32'd0, 32'd100);
      push_exp(0, 64'd42, 1'b0); push_exp(2, 64'd0, 1'b0);
    end
    drain(400);

    // Reset in the middle of WAIT: no response may follow.
    push_req(3, 32'd65535, 32'd65535);
    wait_load("rst_load_seen");
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    pend.delete(); exp_q.delete();
    drive();
    #1;
    chk_all_zero("midrst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_idle", 64'(busy), 64'd0);
    push_req(0, 32'd16, 32'd4); push_exp(0, 64'd64, 1'b0);
    drain(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin arbiter and sequencer that shares one `unsigned_multiplier` instance among `NREQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and drives the multiplier's `load`/`recieved` protocol. It returns each 2N-bit product to the requester that issued it. It sits between the multiplier and the client blocks, and the multiplier is never driven directly by clients.

## Interface
- `N`, 32, operand width; must match the multiplier's `N`.
- `NREQ`, 4, number of requesters, ≥2.
- `TIMEOUT`, 4096, max cycles in WAIT before an error response; ≥ `N`+4.
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high; one clock domain. Integration ties the multiplier `rst_n` to `~rst`.
- `req_valid`  in  NREQ  per-requester operand valid
- `req_ready`  out  NREQ  one-hot accept
- `req_a`  in  NREQ*N  operand A; requester i at bits [i*N +: N]
- `req_b`  in  NREQ*N  operand B; same packing
- `rsp_valid`  out  NREQ  one-hot result valid
- `rsp_ready`  in  NREQ  per-requester result accept
- `rsp_c`  out  2N  product, shared bus
- `rsp_err`  out  1  qualifies `rsp_valid`; 1 = timeout and `rsp_c`=0
- `mul_load`  out  1  to multiplier `load`
- `mul_recieved`  out  1  to multiplier `recieved`
- `mul_a`, `mul_b`  out  N  to multiplier `A`/`B`; registered
- `mul_done`  in  1  from multiplier `done`
- `mul_init`  in  1  from multiplier `init`; 1 = multiplier idle
- `mul_c`  in  2N  from multiplier `C`
- `busy`  out  1  state ≠ IDLE
- `grant_id`  out  $clog2(NREQ)  index of current or last owner

## Operation
- FSM states: IDLE, LOAD, WAIT, RESP, RELEASE.
- **IDLE:**
  - Grant only when `mul_init`=1 and any `req_valid`.
  - Winner is the lowest index ≥ `rr_ptr`; if none, the lowest index overall (wrap-around).
  - `req_ready[winner]`=1 combinationally in that cycle.
  - At the clock edge: latch `req_a`/`req_b` of the winner into `mul_a`/`mul_b`, set `grant_id`, go to LOAD.
- **LOAD:** `mul_load`=1 for exactly one cycle; clear the timeout counter; go to WAIT.
- **WAIT:**
  - If `mul_done`=1: register `rsp_c`←`mul_c`, `rsp_err`←0, go to RESP.
  - Else, when the counter reaches `TIMEOUT`-1: `rsp_c`←0, `rsp_err`←1, go to RESP.
- **RESP:**
  - `rsp_valid[grant_id]`=1 and `rsp_c`/`rsp_err` stable until `rsp_ready[grant_id]`=1.
  - On handshake: `rr_ptr`←(`grant_id`+1) mod NREQ, go to RELEASE.
- **RELEASE:** `mul_recieved`=1 for exactly one cycle; go to IDLE.
  - The IDLE `mul_init` qualifier blocks re-grant until the multiplier is back in its idle state.
- **Rules:**
  - `req_ready` is 0 outside IDLE.
  - Only one operation is in flight at a time.
  - `rsp_ready` of non-owners is ignored.
  - Requesters hold `req_valid`/`req_a`/`req_b` stable until accepted.
  - The product is 2N bits with no truncation; the arbiter never alters `mul_c`.

## Timing
- **Reset values:** all outputs 0 (`req_ready`, `rsp_valid`, `rsp_c`, `rsp_err`, `mul_load`, `mul_recieved`, `mul_a`, `mul_b`, `busy`, `grant_id`); `rr_ptr`=0; state IDLE.
- **Reset mid-operation:** returns immediately to the values above. Any in-flight result is discarded and no response is issued.
- **Latency:** accept at edge T → `mul_load` high in cycle T+1 → `rsp_valid` high the cycle after `mul_done` is first sampled high.
- **Arbiter overhead:** 3 cycles + response stall + 1 RELEASE cycle on top of the multiplier latency.
- **Back-to-back throughput:** next accept ≥1 cycle after RELEASE, and only once `mul_init`=1.
- **Simultaneous events:**
  - `mul_done` and timeout expiry in the same cycle: `mul_done` wins and `rsp_err`=0.
  - A `req_valid` assertion in the same cycle as the RELEASE→IDLE transition is considered in the following IDLE cycle.
- **Stuck multiplier:** if `mul_init` never rises after RELEASE, the arbiter stays in IDLE and accepts nothing; this is not an error.

## Test plan
- **Single request:** req0 A=5 B=3 → one `mul_load` pulse, then `rsp_valid`=0001, `rsp_c`=15, `rsp_err`=0, one `mul_recieved` pulse after `rsp_ready[0]`.
- **All four requesters valid at once:** A=i+1, B=10 → grants in order 0,1,2,3 with products 10,20,30,40. Requester 0 then re-requests while 2 and 3 are valid → served after 2 and 3.
- **Backpressure:** req1 0xFFFFFFFF×0xFFFFFFFF with `rsp_ready[1]` held low 10 cycles → `rsp_valid[1]` and `rsp_c`=0xFFFFFFFE00000001 stable throughout. No `mul_recieved` and no new `req_ready` until the handshake.
- **Timeout:** `TIMEOUT`=100 with multiplier model `mul_done` held 0 → `rsp_valid` exactly 100 cycles after WAIT entry, `rsp_err`=1, `rsp_c`=0. `mul_recieved` still pulses.
- **Fairness:** req0 and req2 continuously valid with 7×6 and 0×100 → alternating grants 0,2,0,2, results 42 and 0.
- **Reset mid-WAIT:** `rst` pulsed during a 65535×65535 operation → all outputs 0 immediately and no response. Next request 16×4 → `rsp_c`=64 on requester 0.
